// File: rtl/uart_pkg.sv
// Shared definitions for the APB UART transmitter: register offsets, STATUS/CTRL
// bit positions, the TX state type and a helper that packs the STATUS word.
package uart_pkg;

    localparam logic [3:0] UART_TXDATA = 4'h0;
    localparam logic [3:0] UART_STATUS = 4'h4;
    localparam logic [3:0] UART_CTRL   = 4'h8;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_EMPTY     = 2;
    localparam int STAT_COUNT_LSB = 4;
    localparam int STAT_COUNT_W   = 4;

    localparam int CTRL_TX_EN  = 0;
    localparam int CTRL_IRQ_EN = 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

    typedef struct packed {
        logic irq_en;
        logic tx_en;
    } uart_ctrl_t;

    function automatic logic [31:0] status_word(input logic busy,
                                                input logic full,
                                                input logic empty,
                                                input logic [STAT_COUNT_W-1:0] count);
        logic [31:0] w;
        w = '0;
        w[STAT_BUSY]  = busy;
        w[STAT_FULL]  = full;
        w[STAT_EMPTY] = empty;
        w[STAT_COUNT_LSB +: STAT_COUNT_W] = count;
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter. Head is visible combinationally;
// a push while full is dropped even if a pop happens on the same edge.
module uart_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [7:0]             wdata,
    output logic [7:0]             rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/apb_uart_tx.sv
// APB-attached 8N1 UART transmitter: register decode, CTRL register, TX FIFO
// and the serialising FSM with baud and bit counters.
//
// state | meaning
// IDLE  | line high; pops the FIFO head when tx_en and data are present
// START | line low for one bit period
// DATA  | line = shift[0]; shift right after each of the 8 bits
// STOP  | line high for one bit period, then back to IDLE
module apb_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 286,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    input  logic        PWRITE,
    input  logic        PENABLE,
    input  logic        PSEL,
    output logic [31:0] PRDATA,
    output logic        pslverr,
    output logic        serial_out,
    output logic        tx_irq
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    uart_tx_state_t    state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              serial_out_q, serial_out_d;
    uart_ctrl_t        ctrl_q, ctrl_d;

    logic [3:0]        addr;
    logic              access;
    logic              addr_ok;
    logic              wr_err;
    logic              baud_done;
    logic              fifo_push;
    logic              fifo_pop;
    logic [7:0]        fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              unused_bits;

    assign unused_bits = ^{PADDR[31:4], PWDATA[31:8]};

    assign addr    = PADDR[3:0];
    assign access  = PSEL && PENABLE;
    assign addr_ok = addr inside {UART_TXDATA, UART_STATUS, UART_CTRL};
    assign wr_err  = PWRITE && (((addr == UART_TXDATA) && fifo_full) || (addr == UART_STATUS));
    assign pslverr = access && (!addr_ok || wr_err);

    assign fifo_push = access && PWRITE && (addr == UART_TXDATA) && !fifo_full;

    always_comb begin
        ctrl_d = ctrl_q;
        if (access && PWRITE && (addr == UART_CTRL)) ctrl_d = uart_ctrl_t'(PWDATA[1:0]);
    end

    always_comb begin
        PRDATA = '0;
        if (PSEL) begin
            case (addr)
                UART_STATUS: PRDATA = status_word(state_q != IDLE, fifo_full, fifo_empty,
                                                  STAT_COUNT_W'(fifo_count));
                UART_CTRL:   PRDATA = {30'b0, ctrl_q};
                default:     PRDATA = '0;
            endcase
        end
    end

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (PWDATA[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign baud_done = (baud_q == BAUD_LAST);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q + BAUD_W'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (ctrl_q.tx_en && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The line follows the state one clock later so it comes straight from a flop.
    always_comb begin
        case (state_q)
            START:   serial_out_d = 1'b0;
            DATA:    serial_out_d = shift_q[0];
            default: serial_out_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            baud_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            serial_out_q <= 1'b1;
            ctrl_q       <= '0;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            serial_out_q <= serial_out_d;
            ctrl_q       <= ctrl_d;
        end
    end

    assign serial_out = serial_out_q;
    assign tx_irq     = ctrl_q.irq_en && fifo_empty && (state_q == IDLE);

endmodule

// File: tb/tb_apb_uart_tx.sv
// Self-checking bench for apb_uart_tx: APB driver, mid-bit UART receiver and a
// queue-based model of the FIFO contents and STATUS word.
module tb_apb_uart_tx;

    localparam int CPB   = 286;
    localparam int HALF  = 143;
    localparam int DEPTH = 8;
    localparam int FALL_LIMIT = 4000;

    logic        clk;
    logic        n_rst;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PENABLE;
    logic        PSEL;
    logic [31:0] PRDATA;
    logic        pslverr;
    logic        serial_out;
    logic        tx_irq;

    apb_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PWRITE     (PWRITE),
        .PENABLE    (PENABLE),
        .PSEL       (PSEL),
        .PRDATA     (PRDATA),
        .pslverr    (pslverr),
        .serial_out (serial_out),
        .tx_irq     (tx_irq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_status(input bit busy, input int cnt);
        logic [31:0] w;
        w = 32'(cnt) << 4;
        if (cnt == 0)     w = w | 32'h4;
        if (cnt == DEPTH) w = w | 32'h2;
        if (busy)         w = w | 32'h1;
        return w;
    endfunction

    function automatic logic [9:0] exp_frame(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, output logic err);
        @(negedge clk);
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = addr; PWDATA = data; PENABLE = 1'b0;
        @(negedge clk);
        PENABLE = 1'b1;
        #1 err = pslverr;
        @(negedge clk);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output logic err);
        @(negedge clk);
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = addr; PENABLE = 1'b0;
        @(negedge clk);
        PENABLE = 1'b1;
        #1 begin data = PRDATA; err = pslverr; end
        @(negedge clk);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic wait_fall(output bit found);
        found = 1'b0;
        for (int k = 0; k < FALL_LIMIT; k++) begin
            @(negedge clk);
            if (serial_out === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) chk("rx_start_timeout", 32'd0, 32'd1);
    endtask

    // Samples 10 line bits at mid-bit; clr_idx >= 0 clears CTRL right after that sample.
    task automatic rx_frame(input bit started, input bit check_busy, input int clr_idx,
                            output logic [9:0] bits, output int unsigned fall_cyc);
        bit          found;
        logic [31:0] rd;
        logic        err;
        int          used;
        bits = '0;
        fall_cyc = 0;
        if (!started) begin
            wait_fall(found);
            if (!found) return;
        end
        fall_cyc = cyc;
        repeat (HALF - 1) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            bits[i] = serial_out;
            used = 0;
            if (check_busy) begin
                apb_read({28'd0, 4'h4}, rd, err);
                chk("busy_mid_frame", {31'd0, rd[0]}, 32'd1);
                used += 3;
            end
            if (i == clr_idx) begin
                apb_write({28'd0, 4'h8}, 32'd0, err);
                used += 3;
            end
            if (i != 9) repeat (CPB - used) @(negedge clk);
        end
    endtask

    logic [31:0]  rd;
    logic         err;
    logic [9:0]   fr;
    logic [7:0]   b, a_byte, z_byte;
    int unsigned  f1, f2;
    bit           found;
    int           n, lows;

    initial begin
        repeat (120000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    initial begin
        n_rst = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        chk("reset_serial_out", {31'd0, serial_out}, 32'd1);
        chk("reset_tx_irq", {31'd0, tx_irq}, 32'd0);
        apb_read(32'h4, rd, err);
        chk("reset_status", rd, 32'h4);
        chk("reset_pslverr", {31'd0, err}, 32'd0);

        // Single frame with latency and busy checks
        apb_write(32'h8, 32'h1, err);
        apb_read(32'h8, rd, err);
        chk("ctrl_readback", rd, 32'h1);
        apb_write(32'h0, 32'hA9, err);
        chk("first_write_err", {31'd0, err}, 32'd0);
        chk("latency_edge_n", {31'd0, serial_out}, 32'd1);
        @(negedge clk);
        chk("latency_edge_n1", {31'd0, serial_out}, 32'd1);
        @(negedge clk);
        chk("latency_edge_n2", {31'd0, serial_out}, 32'd0);
        rx_frame(1'b1, 1'b1, -1, fr, f1);
        chk("frame_a9", {22'd0, fr}, {22'd0, exp_frame(8'hA9)});
        repeat (200) @(negedge clk);
        apb_read(32'h4, rd, err);
        chk("status_after_a9", rd, exp_status(0, 0));

        // Fill with tx_en off, overflow and error accesses
        apb_write(32'h8, 32'h0, err);
        for (int i = 1; i <= DEPTH + 1; i++) begin
            apb_write(32'h0, 32'(i), err);
            chk("fill_pslverr", {31'd0, err}, {31'd0, exp_q.size() >= DEPTH});
            if (exp_q.size() < DEPTH) exp_q.push_back(8'(i));
        end
        apb_read(32'h4, rd, err);
        chk("status_full", rd, exp_status(0, exp_q.size()));
        apb_write(32'h4, 32'hFF, err);
        chk("write_status_err", {31'd0, err}, 32'd1);
        apb_read(32'hC, rd, err);
        chk("read_unmapped_err", {31'd0, err}, 32'd1);
        chk("read_unmapped_data", rd, 32'd0);
        apb_write(32'hC, 32'h3, err);
        chk("write_unmapped_err", {31'd0, err}, 32'd1);
        apb_read(32'h0, rd, err);
        chk("read_txdata", rd, 32'd0);
        chk("read_txdata_err", {31'd0, err}, 32'd0);
        apb_read(32'h8, rd, err);
        chk("ctrl_after_errors", rd, 32'h0);
        apb_read(32'h4, rd, err);
        chk("status_after_errors", rd, exp_status(0, exp_q.size()));
        apb_write(32'h8, 32'h1, err);
        while (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            rx_frame(1'b0, 1'b0, -1, fr, f1);
            chk("fifo_frame", {22'd0, fr}, {22'd0, exp_frame(b)});
        end
        repeat (200) @(negedge clk);
        apb_read(32'h4, rd, err);
        chk("status_drained", rd, exp_status(0, 0));

        // Back-to-back frames and interrupt level
        apb_write(32'h8, 32'h2, err);
        chk("irq_idle_empty", {31'd0, tx_irq}, 32'd1);
        apb_write(32'h0, 32'hA9, err);
        chk("irq_nonempty", {31'd0, tx_irq}, 32'd0);
        apb_write(32'h0, 32'h6A, err);
        apb_write(32'h8, 32'h3, err);
        rx_frame(1'b0, 1'b0, -1, fr, f1);
        chk("b2b_first", {22'd0, fr}, {22'd0, exp_frame(8'hA9)});
        rx_frame(1'b0, 1'b0, -1, fr, f2);
        chk("b2b_second", {22'd0, fr}, {22'd0, exp_frame(8'h6A)});
        chk("b2b_spacing", f2 - f1, 32'(10 * CPB + 1));
        repeat (200) @(negedge clk);
        chk("irq_after_b2b", {31'd0, tx_irq}, 32'd1);

        // Randomized bursts
        for (int r = 0; r < 2; r++) begin
            apb_write(32'h8, 32'h0, err);
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                apb_write(32'h0, {24'd0, b}, err);
                exp_q.push_back(b);
            end
            apb_read(32'h4, rd, err);
            chk("rand_status", rd, exp_status(0, exp_q.size()));
            apb_write(32'h8, 32'h1, err);
            while (exp_q.size() > 0) begin
                b = exp_q.pop_front();
                rx_frame(1'b0, 1'b0, -1, fr, f1);
                chk("rand_frame", {22'd0, fr}, {22'd0, exp_frame(b)});
            end
            repeat (200) @(negedge clk);
            apb_read(32'h4, rd, err);
            chk("rand_drained", rd, exp_status(0, 0));
        end

        // tx_en cleared during data bit 3
        apb_write(32'h8, 32'h0, err);
        a_byte = 8'($urandom);
        b = 8'($urandom);
        apb_write(32'h0, {24'd0, a_byte}, err);
        apb_write(32'h0, {24'd0, b}, err);
        exp_q.push_back(a_byte);
        exp_q.push_back(b);
        apb_write(32'h8, 32'h1, err);
        rx_frame(1'b0, 1'b0, 4, fr, f1);
        chk("clr_frame", {22'd0, fr}, {22'd0, exp_frame(exp_q.pop_front())});
        lows = 0;
        for (int k = 0; k < 3 * CPB; k++) begin
            @(negedge clk);
            if (serial_out !== 1'b1) lows++;
        end
        chk("clr_line_idle", 32'(lows), 32'd0);
        apb_read(32'h4, rd, err);
        chk("clr_retained", rd, exp_status(0, exp_q.size()));

        // Reset asserted during data bit 5
        z_byte = 8'($urandom) & 8'hDF;
        apb_write(32'h0, {24'd0, z_byte}, err);
        apb_write(32'h0, {24'd0, 8'($urandom)}, err);
        apb_write(32'h8, 32'h1, err);
        rx_frame(1'b0, 1'b0, -1, fr, f1);
        chk("pre_reset_frame", {22'd0, fr}, {22'd0, exp_frame(exp_q.pop_front())});
        wait_fall(found);
        repeat (HALF - 1 + 6 * CPB) @(negedge clk);
        chk("bit5_low", {31'd0, serial_out}, 32'd0);
        #3 n_rst = 1'b0;
        #1 chk("async_reset_line", {31'd0, serial_out}, 32'd1);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        exp_q.delete();
        apb_read(32'h4, rd, err);
        chk("status_after_reset", rd, exp_status(0, exp_q.size()));
        apb_read(32'h8, rd, err);
        chk("ctrl_after_reset", rd, 32'h0);
        chk("line_after_reset", {31'd0, serial_out}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
